move_arbiter: RTL and testbench

- Arbitrates all piece-movement requesters onto the single move/collision port of the board datapath:
  - keyboard commands (left, right, soft-down, rotate, with auto-repeat)
  - the gravity tick
- Issues one move at a time over a req/ack handshake.
- Detects a blocked downward move and sequences the lock/spawn phase.
- Sits between the keyboard decode and speed counters (upstream) and the board datapath (downstream). Active only while the gameplay screen is enabled.

---
 rtl/move_arbiter.sv | 219 +++++++++++++++++++++
 tb/tb_move_arbiter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/move_arbiter.sv
// rtl/move_arbiter.sv - piece-move arbiter between keyboard/gravity sources and the board datapath
//
// Purpose: collects keyboard commands (with auto-repeat) and gravity ticks,
// issues one move at a time over the mv_req/mv_ack handshake and sequences
// the lock/spawn phase after a blocked downward move.
//
// Optional feature macro: MOVE_ARB_HARD_DROP_EN (space bar hard drop).
//
// Ports:
//   CLOCK_50     in   system clock, rising edge
//   reset        in   asynchronous active-high reset
//   enable       in   gameplay active; low blocks new requests
//   key_code     in   [7:0] current make code, 8'h00 = no key
//   grav_tick    in   one-cycle gravity pulse
//   rep_tick     in   one-cycle auto-repeat time base
//   mv_ack       in   datapath accepted/evaluated current move
//   mv_blocked   in   qualifies mv_ack: move collided
//   spawn_done   in   datapath finished lock and spawned next piece
//   mv_req       out  move request valid
//   mv_op        out  [2:0] 1=LEFT 2=RIGHT 3=SOFT_DOWN 4=ROTATE 5=GRAV_DOWN
//   lock_pulse   out  one-cycle: piece must lock
//   grav_dropped out  one-cycle: gravity tick lost
module move_arbiter #(
  parameter int REPEAT_DELAY = 4,
  parameter int REPEAT_RATE  = 2
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] key_code,
  input  logic       grav_tick,
  input  logic       rep_tick,
  input  logic       mv_ack,
  input  logic       mv_blocked,
  input  logic       spawn_done,
  output logic       mv_req,
  output logic [2:0] mv_op,
  output logic       lock_pulse,
  output logic       grav_dropped
);

  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_LEFT  = 3'd1;
  localparam logic [2:0] OP_RIGHT = 3'd2;
  localparam logic [2:0] OP_SOFT  = 3'd3;
  localparam logic [2:0] OP_ROT   = 3'd4;
  localparam logic [2:0] OP_GRAV  = 3'd5;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_LOCK_WAIT} state_t;

  state_t     r_state;
  logic [7:0] r_prev_code;
  logic [3:0] r_rep_cnt;
  logic       r_rep_first;   // first auto-repeat already fired for this hold
  logic       r_key_pend;
  logic [2:0] r_key_op;
  logic       r_grav_pend;
  logic       r_mv_req;
  logic [2:0] r_mv_op;
  logic       r_lock_pulse;
  logic       r_grav_dropped;

  logic [2:0] w_cmd;
  logic       w_changed;
  logic       w_press;
  logic       w_repeatable;
  logic       w_rep_step;
  logic [3:0] w_rep_cnt_nxt;
  logic       w_rep_fire;
  logic       w_key_set;
  logic       w_idle_en;
  logic       w_drop_go;
  logic       w_drop_active;
  logic       w_key_clr;
  logic       w_grav_issue;
  logic       w_ack;
  logic       w_grav_clr;

  always_comb begin
    w_cmd = OP_NONE;
    case (key_code)
      8'h1C:   w_cmd = OP_LEFT;
      8'h23:   w_cmd = OP_RIGHT;
      8'h1B:   w_cmd = OP_SOFT;
      8'h1D:   w_cmd = OP_ROT;
      default: w_cmd = OP_NONE;
    endcase
  end

  assign w_changed     = (key_code != r_prev_code);
  assign w_press       = w_changed && (w_cmd != OP_NONE);
  assign w_repeatable  = (w_cmd == OP_LEFT) || (w_cmd == OP_RIGHT) || (w_cmd == OP_SOFT);
  assign w_rep_step    = !w_changed && w_repeatable && rep_tick;
  assign w_rep_cnt_nxt = r_rep_cnt + 4'd1;
  // First repeat waits REPEAT_DELAY ticks, later ones REPEAT_RATE ticks.
  assign w_rep_fire    = w_rep_step &&
                         (r_rep_first ? (w_rep_cnt_nxt == 4'(REPEAT_RATE))
                                      : (w_rep_cnt_nxt == 4'(REPEAT_DELAY)));
  assign w_key_set     = w_press || w_rep_fire;

`ifdef MOVE_ARB_HARD_DROP_EN
  logic r_drop_pend;
  logic r_dropping;   // hard drop in progress until a blocked ack
  logic w_drop_press;
  assign w_drop_press  = w_changed && (key_code == 8'h29);
  assign w_drop_go     = w_idle_en && (r_drop_pend || r_dropping);
  assign w_drop_active = r_drop_pend || r_dropping;
`else
  assign w_drop_go     = 1'b0;
  assign w_drop_active = 1'b0;
`endif

  assign w_idle_en    = (r_state == S_IDLE) && enable;
  assign w_key_clr    = w_idle_en && !w_drop_go && r_key_pend;
  assign w_grav_issue = w_idle_en && !w_drop_go && !r_key_pend && r_grav_pend;
  assign w_ack        = (r_state == S_ISSUE) && mv_ack;
  // An unblocked soft drop already moved the piece one row, so it consumes gravity.
  assign w_grav_clr   = w_grav_issue || (w_ack && (r_mv_op == OP_SOFT) && !mv_blocked);

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_prev_code    <= 8'h00;
      r_rep_cnt      <= 4'd0;
      r_rep_first    <= 1'b0;
      r_key_pend     <= 1'b0;
      r_key_op       <= OP_NONE;
      r_grav_pend    <= 1'b0;
      r_mv_req       <= 1'b0;
      r_mv_op        <= OP_NONE;
      r_lock_pulse   <= 1'b0;
      r_grav_dropped <= 1'b0;
`ifdef MOVE_ARB_HARD_DROP_EN
      r_drop_pend    <= 1'b0;
      r_dropping     <= 1'b0;
`endif
    end else begin
      r_prev_code    <= key_code;
      r_lock_pulse   <= 1'b0;
      r_grav_dropped <= 1'b0;

      if (!enable || w_changed) begin
        r_rep_cnt   <= 4'd0;
        r_rep_first <= 1'b0;
      end else if (w_rep_step) begin
        if (w_rep_fire) begin
          r_rep_cnt   <= 4'd0;
          r_rep_first <= 1'b1;
        end else begin
          r_rep_cnt   <= w_rep_cnt_nxt;
        end
      end

      if (w_key_set) r_key_op <= w_cmd;

      // Set beats clear, so an event on the issue edge is never lost.
      if (!enable || w_drop_active) begin
        r_key_pend  <= 1'b0;
        r_grav_pend <= 1'b0;
      end else begin
        r_key_pend     <= w_key_set || (r_key_pend && !w_key_clr);
        r_grav_pend    <= grav_tick || (r_grav_pend && !w_grav_clr);
        r_grav_dropped <= grav_tick && r_grav_pend && !w_grav_clr;
      end

`ifdef MOVE_ARB_HARD_DROP_EN
      if (!enable) begin
        r_drop_pend <= 1'b0;
        r_dropping  <= 1'b0;
      end else begin
        if (w_drop_go) begin
          r_drop_pend <= 1'b0;
          r_dropping  <= 1'b1;
        end else if (w_drop_press && !r_dropping) begin
          r_drop_pend <= 1'b1;
        end
        if (w_ack && mv_blocked) r_dropping <= 1'b0;
      end
`endif

      case (r_state)
        S_IDLE: begin
          if (w_drop_go || w_key_clr) begin
            r_mv_req <= 1'b1;
            r_mv_op  <= w_drop_go ? OP_SOFT : r_key_op;
            r_state  <= S_ISSUE;
          end else if (w_grav_issue) begin
            r_mv_req <= 1'b1;
            r_mv_op  <= OP_GRAV;
            r_state  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // Request is held regardless of enable until the datapath answers.
          if (mv_ack) begin
            r_mv_req <= 1'b0;
            r_mv_op  <= OP_NONE;
            if (((r_mv_op == OP_SOFT) || (r_mv_op == OP_GRAV)) && mv_blocked) begin
              r_lock_pulse <= 1'b1;
              r_state      <= S_LOCK_WAIT;
            end else begin
              r_state      <= S_IDLE;
            end
          end
        end
        S_LOCK_WAIT: begin
          if (spawn_done) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mv_req       = r_mv_req;
  assign mv_op        = r_mv_op;
  assign lock_pulse   = r_lock_pulse;
  assign grav_dropped = r_grav_dropped;

endmodule

// File: tb/tb_move_arbiter.sv
// tb/tb_move_arbiter.sv - self-checking bench for move_arbiter
module tb_move_arbiter;

  logic       CLOCK_50 = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic [7:0] key_code = 8'h00;
  logic       grav_tick = 1'b0;
  logic       rep_tick = 1'b0;
  logic       mv_ack = 1'b0;
  logic       mv_blocked = 1'b0;
  logic       spawn_done = 1'b0;
  logic       mv_req;
  logic [2:0] mv_op;
  logic       lock_pulse;
  logic       grav_dropped;

  int n_checks = 0;
  int n_fail   = 0;
  int n_req    = 0;
  int cnt_lock = 0;
  int cnt_drop = 0;
  int base_req, base_lock, base_drop;
  logic ack_en   = 1'b0;
  logic blk_val  = 1'b0;
  int   blk_cnt  = 0;
  logic prev_req = 1'b0;
  logic [2:0] exp_q[$];

  move_arbiter #(.REPEAT_DELAY(4), .REPEAT_RATE(2)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .enable(enable), .key_code(key_code),
    .grav_tick(grav_tick), .rep_tick(rep_tick), .mv_ack(mv_ack),
    .mv_blocked(mv_blocked), .spawn_done(spawn_done), .mv_req(mv_req),
    .mv_op(mv_op), .lock_pulse(lock_pulse), .grav_dropped(grav_dropped)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  // Datapath model: acks any request one cycle after it appears.
  always @(negedge CLOCK_50) begin
    if (ack_en && mv_req) begin
      mv_ack = 1'b1;
      if (blk_cnt > 0) begin
        mv_blocked = 1'b0;
        blk_cnt--;
      end else begin
        mv_blocked = blk_val;
      end
    end else begin
      mv_ack = 1'b0;
      mv_blocked = 1'b0;
    end
  end

  // Monitor: every new request is matched against the scoreboard.
  always @(negedge CLOCK_50) begin
    logic [2:0] exp_op;
    if (lock_pulse) cnt_lock++;
    if (grav_dropped) cnt_drop++;
    if (mv_req && !prev_req) begin
      n_req++;
      exp_op = (exp_q.size() > 0) ? exp_q.pop_front() : 3'd0;
      chk("req_op", {5'd0, mv_op}, {5'd0, exp_op});
    end
    prev_req = mv_req;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    cyc(2);
    chk("rst_req", {7'd0, mv_req}, 8'd0);
    chk("rst_op", {5'd0, mv_op}, 8'd0);
    chk("rst_lock", {7'd0, lock_pulse}, 8'd0);
    chk("rst_gdrop", {7'd0, grav_dropped}, 8'd0);
    reset = 1'b0;
    cyc(2);

    // Single LEFT press, latency edge k+1
    enable = 1'b1; ack_en = 1'b1; base_req = n_req;
    key_code = 8'h1C; exp_q.push_back(3'd1);
    cyc(1);
    chk("lat_req_k", {7'd0, mv_req}, 8'd0);
    cyc(1);
    chk("lat_req_k1", {7'd0, mv_req}, 8'd1);
    chk("lat_op_k1", {5'd0, mv_op}, 8'd1);
    cyc(1);
    chk("lat_req_ack", {7'd0, mv_req}, 8'd0);
    cyc(3); key_code = 8'h00; cyc(4);
    chk("left_count", 8'(n_req - base_req), 8'd1);

    // Held RIGHT with auto-repeat: press + ticks 4,6,8,10
    base_req = n_req;
    key_code = 8'h23; exp_q.push_back(3'd2);
    cyc(5);
    for (int t = 1; t <= 10; t++) begin
      if (t == 4 || t == 6 || t == 8 || t == 10) exp_q.push_back(3'd2);
      rep_tick = 1'b1; cyc(1); rep_tick = 1'b0; cyc(4);
    end
    key_code = 8'h00; cyc(4);
    chk("rep_count", 8'(n_req - base_req), 8'd5);
    chk("rep_q_empty", 8'(exp_q.size()), 8'd0);

    // Gravity overrun during a held ROTATE
    ack_en = 1'b0; base_req = n_req; base_drop = cnt_drop;
    key_code = 8'h1D; exp_q.push_back(3'd4);
    cyc(3);
    chk("rot_req", {7'd0, mv_req}, 8'd1);
    chk("rot_op", {5'd0, mv_op}, 8'd4);
    exp_q.push_back(3'd5);
    grav_tick = 1'b1; cyc(1); grav_tick = 1'b0; cyc(1);
    grav_tick = 1'b1; cyc(1); grav_tick = 1'b0; cyc(2);
    chk("gdrop_once", 8'(cnt_drop - base_drop), 8'd1);
    chk("rot_held_op", {5'd0, mv_op}, 8'd4);
    key_code = 8'h00; ack_en = 1'b1; cyc(6);
    chk("rot_grav_count", 8'(n_req - base_req), 8'd2);
    chk("gdrop_final", 8'(cnt_drop - base_drop), 8'd1);

    // Unblocked SOFT_DOWN consumes a pending gravity tick
    ack_en = 1'b0; base_req = n_req;
    key_code = 8'h1B; exp_q.push_back(3'd3);
    cyc(3);
    grav_tick = 1'b1; cyc(1); grav_tick = 1'b0;
    key_code = 8'h00; ack_en = 1'b1; cyc(6);
    chk("soft_eats_grav", 8'(n_req - base_req), 8'd1);

    // Blocked GRAV_DOWN -> lock, key held off until spawn_done
    base_req = n_req; base_lock = cnt_lock; blk_val = 1'b1;
    exp_q.push_back(3'd5);
    grav_tick = 1'b1; cyc(1); grav_tick = 1'b0; cyc(4);
    blk_val = 1'b0;
    key_code = 8'h1C; cyc(6);
    chk("lock_once", 8'(cnt_lock - base_lock), 8'd1);
    chk("lock_no_req", 8'(n_req - base_req), 8'd1);
    chk("lock_req_low", {7'd0, mv_req}, 8'd0);
    exp_q.push_back(3'd1);
    spawn_done = 1'b1; cyc(1); spawn_done = 1'b0; cyc(5);
    chk("spawn_left", 8'(n_req - base_req), 8'd2);
    key_code = 8'h00; cyc(3);

    // Reset in the middle of a ROTATE issue
    ack_en = 1'b0; base_lock = cnt_lock;
    key_code = 8'h1D; exp_q.push_back(3'd4);
    cyc(3);
    chk("mid_req", {7'd0, mv_req}, 8'd1);
    chk("mid_op", {5'd0, mv_op}, 8'd4);
    reset = 1'b1; key_code = 8'h00;
    cyc(1);
    chk("mid_rst_req", {7'd0, mv_req}, 8'd0);
    chk("mid_rst_op", {5'd0, mv_op}, 8'd0);
    reset = 1'b0; cyc(3);
    chk("mid_no_lock", 8'(cnt_lock - base_lock), 8'd0);
    chk("mid_idle_req", {7'd0, mv_req}, 8'd0);
    base_req = n_req; ack_en = 1'b1;
    key_code = 8'h1C; exp_q.push_back(3'd1);
    cyc(5); key_code = 8'h00; cyc(2);
    chk("post_rst_left", 8'(n_req - base_req), 8'd1);

    // Enable gating: nothing issued while disabled, held key is not a new press
    base_req = n_req; enable = 1'b0;
    key_code = 8'h23;
    grav_tick = 1'b1; cyc(1); grav_tick = 1'b0; cyc(4);
    enable = 1'b1; cyc(4);
    chk("gate_none", 8'(n_req - base_req), 8'd0);
    key_code = 8'h00; cyc(2);

`ifdef MOVE_ARB_HARD_DROP_EN
    // Hard drop: three unblocked SOFT_DOWNs then a blocked one
    base_req = n_req; base_lock = cnt_lock;
    blk_cnt = 3; blk_val = 1'b1;
    for (int i = 0; i < 4; i++) exp_q.push_back(3'd3);
    key_code = 8'h29; cyc(20);
    chk("hd_count", 8'(n_req - base_req), 8'd4);
    chk("hd_lock", 8'(cnt_lock - base_lock), 8'd1);
    blk_val = 1'b0; key_code = 8'h00;
    spawn_done = 1'b1; cyc(1); spawn_done = 1'b0; cyc(3);
`endif

    chk("final_q_empty", 8'(exp_q.size()), 8'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
